// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit.
// Decodes the latched instruction, sequences FETCH/DECODE/EXECUTE/WRITEBACK,
// keeps the NZCV flags and gates PC, register and memory writes by condition.
// There is no valid/ready handshake: the datapath follows the Moore outputs
// every cycle, and the current state is exported on State for debug.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(9);

  // Instr holds Instr[31:12], so field positions are shifted down by 12.
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic       w_funct5;
  logic [3:0] w_cmd;
  logic       w_sbit;
  logic       w_ubit;
  logic [3:0] w_rd;
  logic       w_unused;

  assign w_cond   = Instr[19:16];
  assign w_op     = Instr[15:14];
  assign w_funct5 = Instr[13];
  assign w_cmd    = Instr[12:9];
  assign w_sbit   = Instr[8];
  assign w_ubit   = Instr[11];
  assign w_rd     = Instr[3:0];
  assign w_unused = ^Instr[7:4];

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [3:0]         r_flags;

  logic [1:0] w_dp_ctl;
  logic       w_cmd_ok;
  logic       w_cmd_arith;
  logic       w_is_cmp;
  logic       w_cond_ex;

  logic w_regw;
  logic w_memw;
  logic w_branch;
  logic w_irw;

  // Data-processing command decode; unknown commands fall back to ADD with no side effects.
  always_comb begin
    w_dp_ctl    = 2'b00;
    w_cmd_ok    = 1'b0;
    w_cmd_arith = 1'b0;
    w_is_cmp    = 1'b0;
    case (w_cmd)
      4'b0100: begin w_dp_ctl = 2'b00; w_cmd_ok = 1'b1; w_cmd_arith = 1'b1; end
      4'b0010: begin w_dp_ctl = 2'b01; w_cmd_ok = 1'b1; w_cmd_arith = 1'b1; end
      4'b0000: begin w_dp_ctl = 2'b10; w_cmd_ok = 1'b1; end
      4'b1100: begin w_dp_ctl = 2'b11; w_cmd_ok = 1'b1; end
      4'b1010: begin w_dp_ctl = 2'b01; w_cmd_ok = 1'b1; w_cmd_arith = 1'b1; w_is_cmp = 1'b1; end
      default: ;
    endcase
  end

  // ARM condition evaluation against the registered flags.
  always_comb begin
    w_cond_ex = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ex = r_flags[2];
      4'b0001: w_cond_ex = ~r_flags[2];
      4'b0010: w_cond_ex = r_flags[1];
      4'b0011: w_cond_ex = ~r_flags[1];
      4'b0100: w_cond_ex = r_flags[3];
      4'b0101: w_cond_ex = ~r_flags[3];
      4'b0110: w_cond_ex = r_flags[0];
      4'b0111: w_cond_ex = ~r_flags[0];
      4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
      4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
      4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
      4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // Next-state selection; a failed condition still walks the full path.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          2'b00:   w_next = w_funct5 ? S_EXECI : S_EXECR;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = w_sbit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR,
      S_EXECI:  w_next = w_is_cmp ? S_FETCH : S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Moore datapath controls and ungated write requests for the current state.
  always_comb begin
    w_regw     = 1'b0;
    w_memw     = 1'b0;
    w_branch   = 1'b0;
    w_irw      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irw = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01; ALUControl = w_ubit ? 2'b00 : 2'b01;
      end
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB:  begin ResultSrc = 2'b01; w_regw = 1'b1; end
      S_MEMWR:  begin AdrSrc = 1'b1; w_memw = 1'b1; end
      S_EXECR:  ALUControl = w_dp_ctl;
      S_EXECI:  begin ALUSrcB = 2'b01; ALUControl = w_dp_ctl; end
      S_ALUWB:  w_regw = w_cmd_ok;
      S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; w_branch = 1'b1; end
      default: ;
    endcase
  end

  // Write enables are condition gated and held low by reset without waiting for a clock.
  assign IRWrite  = reset & w_irw;
  assign RegWrite = reset & w_regw & w_cond_ex;
  assign MemWrite = reset & w_memw & w_cond_ex;
  assign PCWrite  = reset & ((r_state == S_FETCH) |
                             (w_cond_ex & (w_branch | (w_regw & (w_rd == 4'hF)))));

  assign RegSrc = {(w_op == 2'b01), (w_op == 2'b10)};
  assign ImmSrc = w_op;
  assign State  = r_state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // NZCV capture at the end of execute; C,V only move for arithmetic commands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (((r_state == S_EXECR) || (r_state == S_EXECI)) &&
                 w_cond_ex && w_sbit && w_cmd_ok) begin
      r_flags[3:2] <= ALUFlags[3:2];
      if (w_cmd_arith) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-instruction expected state traces
// are pushed to a scoreboard queue and compared cycle by cycle.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [3:0]  State;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [20:0] exp_q[$];
  logic [3:0]  m_flags;   // bench model of NZCV

  logic [20:0] dut_vec;
  assign dut_vec = {State, PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, RegSrc, ImmSrc};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected output word for one state of an instruction.
  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic [1:0] ctl,
                                          input bit tk, input bit wok, input bit rd15,
                                          input logic [1:0] op);
    logic pcw, rw, mw, irw, adr;
    logic [1:0] res, sa, sb, alu;
    pcw = 0; rw = 0; mw = 0; irw = 0; adr = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 2'b00;
    case (st)
      4'd0: begin pcw = 1; irw = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
      4'd1: begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
      4'd2: begin sb = 2'b01; alu = ctl; end
      4'd3: adr = 1;
      4'd4: begin res = 2'b01; rw = tk; pcw = tk & rd15; end
      4'd5: begin adr = 1; mw = tk; end
      4'd6: alu = ctl;
      4'd7: begin sb = 2'b01; alu = ctl; end
      4'd8: begin rw = tk & wok; pcw = tk & wok & rd15; end
      4'd9: begin sb = 2'b01; res = 2'b10; pcw = tk; end
      default: ;
    endcase
    return {st, pcw, rw, mw, irw, adr, res, sa, sb, alu, (op == 2'b01), (op == 2'b10), op};
  endfunction

  // Driver: present one instruction in FETCH, push its expected trace, then
  // compare each cycle at the falling edge. Returns just after the next rising
  // edge unless step_last is 0 (then it stays at the last falling edge).
  task automatic issue(input string name, input logic [31:0] ins, input logic [3:0] af,
                       input logic [23:0] path, input int n, input logic [1:0] ctl,
                       input bit step_last);
    logic [3:0] cmd;
    bit tk, wok, rd15;
    logic [20:0] e;
    Instr    = ins[31:12];
    ALUFlags = af;
    cmd  = ins[24:21];
    tk   = cond_pass(ins[31:28], m_flags);
    wok  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
    rd15 = (ins[15:12] == 4'hF);
    for (int k = 0; k < n; k++)
      exp_q.push_back(exp_vec(path[4*(n-1-k) +: 4], ctl, tk, wok, rd15, ins[27:26]));
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_val($sformatf("%s.cyc%0d", name, k), {11'd0, dut_vec}, {11'd0, e});
      if (k < n - 1 || step_last) begin
        @(posedge clk);
        #1;
      end
    end
    if (ins[27:26] == 2'b00 && tk && ins[20] && (wok || cmd == 4'b1010)) begin
      m_flags[3:2] = af[3:2];
      if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) m_flags[1:0] = af[1:0];
    end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; Instr = '0; ALUFlags = '0; m_flags = 4'b0000;
    #7;
    check_val("rst_state", {28'd0, State}, 32'd0);
    check_val("rst_enables", {28'd0, PCWrite, RegWrite, MemWrite, IRWrite}, 32'd0);
    @(posedge clk); #1;
    check_val("rst_hold_en", {28'd0, PCWrite, RegWrite, MemWrite, IRWrite}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    issue("add",     32'hE0821003, 4'b0000, 24'h0168,  4, 2'b00, 1);
    issue("cmps",    32'hE1520003, 4'b0100, 24'h016,   3, 2'b01, 1);
    issue("beq",     32'h0A000002, 4'b0000, 24'h019,   3, 2'b00, 1);
    issue("bne",     32'h1A000002, 4'b0000, 24'h019,   3, 2'b00, 1);
    issue("ldr",     32'hE5921004, 4'b0000, 24'h01234, 5, 2'b00, 1);
    issue("orrs",    32'hE1921003, 4'b1011, 24'h0168,  4, 2'b11, 1);
    issue("streq",   32'h05821004, 4'b0000, 24'h0125,  4, 2'b00, 1);
    issue("str_sub", 32'hE5021004, 4'b0000, 24'h0125,  4, 2'b01, 1);
    issue("add_pc",  32'hE082F003, 4'b0000, 24'h0168,  4, 2'b00, 1);
    issue("subs_i",  32'hE2521001, 4'b0011, 24'h0178,  4, 2'b01, 1);
    issue("bhi",     32'h8A000000, 4'b0000, 24'h019,   3, 2'b00, 1);
    issue("bge",     32'hAA000000, 4'b0000, 24'h019,   3, 2'b00, 1);
    issue("eors",    32'hE0321003, 4'b1111, 24'h0168,  4, 2'b00, 1);
    issue("bmi",     32'h4A000000, 4'b0000, 24'h019,   3, 2'b00, 1);
    issue("op11",    32'hEC000000, 4'b0000, 24'h01,    2, 2'b00, 1);
    issue("never",   32'hF0821003, 4'b0000, 24'h0168,  4, 2'b00, 1);
    issue("bcc_pre", 32'h3A000000, 4'b0000, 24'h019,   3, 2'b00, 1);

    // abandon an LDR in MEMADR with an asynchronous reset
    issue("ldr_cut", 32'hE5921004, 4'b0000, 24'h012,   3, 2'b00, 0);
    #2 reset = 1'b0;
    m_flags = 4'b0000;
    #1;
    check_val("midrst_state", {28'd0, State}, 32'd0);
    check_val("midrst_en", {28'd0, PCWrite, RegWrite, MemWrite, IRWrite}, 32'd0);
    @(negedge clk);
    check_val("midrst_hold", {24'd0, State, PCWrite, RegWrite, MemWrite, IRWrite}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // flags were cleared, so CC now passes
    issue("bcc_post", 32'h3A000000, 4'b0000, 24'h019,  3, 2'b00, 1);
    issue("ldr2",     32'hE5921004, 4'b0000, 24'h01234, 5, 2'b00, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
